// File: rtl/arp_tx.sv
`timescale 1ns/1ps
// arp_tx: builds single-beat 64-byte ARP reply/request frames onto a 512-bit AXI-Stream master.
// Define ARP_TX_GRAT_EN to add periodic gratuitous ARP announcements every GRAT_PERIOD cycles.
module arp_tx #(
    parameter int          C_AXIS_DATA_WIDTH = 512,
    parameter logic [31:0] GRAT_PERIOD       = 32'd125_000_000
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [47:0]                    local_mac,
    input  logic [31:0]                    local_ip,
    input  logic                           reply_valid,
    output logic                           reply_ready,
    input  logic [47:0]                    reply_dst_mac,
    input  logic [31:0]                    reply_dst_ip,
    input  logic                           request_valid,
    output logic                           request_ready,
    input  logic [31:0]                    request_ip,
    output logic [C_AXIS_DATA_WIDTH-1:0]   tx_m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] tx_m_axis_tkeep,
    output logic                           tx_m_axis_tvalid,
    output logic                           tx_m_axis_tlast,
    input  logic                           tx_m_axis_tready,
    output logic                           busy,
    output logic [15:0]                    tx_frame_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]                   r_state;
    logic [C_AXIS_DATA_WIDTH-1:0] r_tdata;
    logic [15:0]                  r_frame_cnt;

    logic                         w_idle;
    logic                         w_reply_go;
    logic                         w_req_go;
    logic                         w_grat_go;
    logic                         w_start;
    logic                         w_hs;
    logic [511:0]                 w_frame;

    // Byte 0 lands in the top byte of the beat; everything after TPA is zero pad.
    function automatic logic [511:0] build_frame(
        input logic [47:0] dst,
        input logic [15:0] oper,
        input logic [47:0] sha,
        input logic [31:0] spa,
        input logic [47:0] tha,
        input logic [31:0] tpa
    );
        return {dst, sha, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                oper, sha, spa, tha, tpa, 176'd0};
    endfunction

    assign w_idle        = (r_state == S_IDLE);
    assign reply_ready   = w_idle;
    assign request_ready = w_idle && !reply_valid;
    assign w_reply_go    = reply_valid && reply_ready;
    assign w_req_go      = request_valid && request_ready;
    assign w_start       = w_reply_go || w_req_go || w_grat_go;
    assign w_hs          = tx_m_axis_tvalid && tx_m_axis_tready;

`ifdef ARP_TX_GRAT_EN
    logic [31:0] r_grat_tmr;
    logic        r_grat_pending;

    assign w_grat_go = w_idle && r_grat_pending && !reply_valid && !request_valid;

    // A timer expiry outranks the clear so an announcement due in the same cycle is not merged away.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_grat_tmr     <= 32'd0;
            r_grat_pending <= 1'b0;
        end else if (r_grat_tmr == GRAT_PERIOD - 32'd1) begin
            r_grat_tmr     <= 32'd0;
            r_grat_pending <= 1'b1;
        end else begin
            r_grat_tmr <= r_grat_tmr + 32'd1;
            if (w_grat_go)
                r_grat_pending <= 1'b0;
        end
    end
`else
    logic w_unused_grat;

    assign w_grat_go     = 1'b0;
    assign w_unused_grat = ^GRAT_PERIOD;
`endif

    always_comb begin
        w_frame = build_frame(48'hFFFF_FFFF_FFFF, 16'd1, local_mac, local_ip, 48'd0, request_ip);
        if (w_reply_go)
            w_frame = build_frame(reply_dst_mac, 16'd2, local_mac, local_ip, reply_dst_mac, reply_dst_ip);
`ifdef ARP_TX_GRAT_EN
        else if (w_grat_go)
            w_frame = build_frame(48'hFFFF_FFFF_FFFF, 16'd1, local_mac, local_ip, 48'd0, local_ip);
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_tdata     <= '0;
            r_frame_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_tdata <= w_frame;
                        r_state <= S_SEND;
                    end
                end
                default: begin
                    if (w_hs) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign tx_m_axis_tvalid = (r_state == S_SEND);
    assign tx_m_axis_tlast  = tx_m_axis_tvalid;
    assign tx_m_axis_tkeep  = {(C_AXIS_DATA_WIDTH/8){tx_m_axis_tvalid}};
    assign tx_m_axis_tdata  = r_tdata;
    assign busy             = !w_idle;
    assign tx_frame_cnt     = r_frame_cnt;

endmodule
